decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter ENABLE_M, default 1: RV32M decode enabled; when 0, M encodings are illegal.
REQ-002 SHALL have parameter ENABLE_F, default 1: RV32F subset decode enabled; when 0, F encodings are illegal.
REQ-003 SHALL have parameter DEPTH, default 2: output buffer entries; power of two, at least 2.
REQ-004 SHALL have ports, one per line as follows:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered and in-flight decodes
- in_valid  in  1  instruction word offered
- in_ready  out  1  buffer can accept
- in_pc  in  32  PC of offered word
- in_instr  in  32  raw instruction word
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head
- out_op  out  instr_op_t  decoded operation enum
- out_rd, out_rs1, out_rs2  out  5 each  register fields, zeroed where the format lacks them
- out_imm  out  32  sign-extended immediate
- out_pc  out  32  PC of head entry
- out_illegal  out  1  head entry is an illegal encoding
- count  out  $clog2(DEPTH)+1  buffered entries

Function
REQ-005 SHALL decode combinationally from in_instr and push {op, rd, rs1, rs2, imm, pc, illegal} when in_valid && in_ready.
REQ-006 SHALL drive in_ready = !rst && count < DEPTH, with no dependence on out_ready.
REQ-007 SHALL present an entry pushed at cycle N on the outputs with out_valid=1 at cycle N+1 at the earliest.
REQ-008 SHALL pop the head when out_valid && out_ready, and SHALL deliver entries in FIFO order.
REQ-009 SHALL, on a simultaneous push and pop, leave count unchanged and keep both entries correct.
REQ-010 SHALL wrap the read and write pointers modulo DEPTH.
REQ-011 SHALL hold every out_* field stable while out_valid && !out_ready.
REQ-012 SHALL, when flush=1, set count=0 and out_valid=0 on the next cycle.
REQ-013 SHALL ensure an instruction offered during the flush cycle is not stored.
REQ-014 SHALL decode RV32I with srli = f3 101/f7 0000000 and srai = f3 101/f7 0100000.
REQ-015 SHALL require slli f7 = 0000000.
REQ-016 SHALL decode RV32M (opcode 0110011, f7 0000001) only when ENABLE_M=1.
REQ-017 SHALL decode flw, fsw, fadd, fsub, fmul, fdiv, fsqrt, fsgnj, fsgnjn, fsgnjx, feq, fle, fcvt.w.s, fcvt.s.w, fmv.x.w and fmv.w.x, only when ENABLE_F=1.
REQ-018 SHALL require the raw rs2 field = 0 for fsqrt, fcvt and fmv.
REQ-019 SHALL flag any unmatched encoding as illegal: out_op=OP_ILLEGAL, out_illegal=1, out_rd/rs1/rs2=0, out_imm=0.
REQ-020 SHALL sign-extend immediates from bit 31 for I, S, B and J formats.
REQ-021 SHALL form U immediates as {instr[31:12], 12'b0}.
REQ-022 SHALL set out_rd=0 for S and B formats, out_rs1=0 for U and J formats, and out_rs2=0 for I, U and J formats.

Reset
REQ-023 SHALL, while rst=1, clear the read pointer, the write pointer and count.
REQ-024 SHALL hold out_valid=0 and in_ready=0 while rst=1.
REQ-025 SHALL drive every out_* data field to 0 while rst=1.
REQ-026 SHALL treat reset mid-operation like a flush: buffered entries are discarded and none reappear after reset.
REQ-027 SHALL have rst take priority over flush and push.

Structure
REQ-028 SHALL take instr_op_t (including OP_ILLEGAL), the decoded-entry struct and the opcode/funct constants from shared package decode_pkg.
REQ-029 SHALL place the combinational decode in sub-module decode_logic (in_instr, ENABLE_M, ENABLE_F -> decoded struct).
REQ-030 SHALL keep the buffer and its pointers in decode_stage.

Verification
REQ-031 SHALL cover: 0xFFF00093 at pc 0x100 -> next cycle out_op=ADDI, rd=1, rs1=0, imm=0xFFFFFFFF, pc=0x100.
REQ-032 SHALL cover: 0x4041D113 -> out_op=SRAI, rd=2, rs1=3, rs2=0, imm=0x00000404.
REQ-033 SHALL cover: ENABLE_M=0 with 0x023100B3 -> out_illegal=1, out_op=OP_ILLEGAL, rd=rs1=rs2=0; ENABLE_M=1 -> out_op=MUL, rd=1, rs1=2, rs2=3.
REQ-034 SHALL cover: 0xFFDFF0EF -> out_op=JAL, rd=1, imm=0xFFFFFFFC.
REQ-035 SHALL cover: DEPTH=2, out_ready=0, three back-to-back words -> two accepted, in_ready=0 and count=2; out_ready=1 -> in-order drain, then the third is accepted.
REQ-036 SHALL cover: count=2 with flush and in_valid in the same cycle -> next cycle count=0, out_valid=0, and no entry emerges afterwards.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and encoding constants for the decode stage.
package decode_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_LOADFP  = 7'b0000111;
    localparam logic [6:0] OPC_STOREFP = 7'b0100111;
    localparam logic [6:0] OPC_OPFP    = 7'b1010011;

    // Integer funct7 values
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Single-precision OP-FP funct7 values (fmt field = 00)
    localparam logic [6:0] F7_FADD     = 7'b0000000;
    localparam logic [6:0] F7_FSUB     = 7'b0000100;
    localparam logic [6:0] F7_FMUL     = 7'b0001000;
    localparam logic [6:0] F7_FDIV     = 7'b0001100;
    localparam logic [6:0] F7_FSQRT    = 7'b0101100;
    localparam logic [6:0] F7_FSGNJ    = 7'b0010000;
    localparam logic [6:0] F7_FCMP     = 7'b1010000;
    localparam logic [6:0] F7_FCVT_W_S = 7'b1100000;
    localparam logic [6:0] F7_FCVT_S_W = 7'b1101000;
    localparam logic [6:0] F7_FMV_X_W  = 7'b1110000;
    localparam logic [6:0] F7_FMV_W_X  = 7'b1111000;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    // OP_ILLEGAL must stay at encoding 0 so a zeroed entry reads as illegal
    typedef enum logic [6:0] {
        OP_ILLEGAL = 7'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_ECALL, OP_EBREAK,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_FLW, OP_FSW, OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FSQRT,
        OP_FSGNJ, OP_FSGNJN, OP_FSGNJX, OP_FEQ, OP_FLE,
        OP_FCVT_W_S, OP_FCVT_S_W, OP_FMV_X_W, OP_FMV_W_X
    } instr_op_t;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } instr_fmt_t;

    typedef struct packed {
        instr_op_t   op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } decoded_t;

    typedef struct packed {
        decoded_t    dec;
        logic [31:0] pc;
    } entry_t;

    // Immediate extraction; formats without an immediate yield 0
    function automatic logic [31:0] imm_of(input instr_fmt_t fmt, input logic [31:0] i);
        logic [31:0] imm;
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{i[31]}}, i[31:20]};
            FMT_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
            FMT_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            FMT_U:   imm = {i[31:12], 12'b0};
            FMT_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32I/M/F-subset instruction decoder.
module decode_logic
    import decode_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1,
    parameter bit ENABLE_F = 1'b1
) (
    input  logic [31:0] in_instr,
    output decoded_t    dec
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs2_raw;
    logic       rm_ok;
    instr_op_t  op;
    instr_fmt_t fmt;

    assign opcode  = in_instr[6:0];
    assign f3      = in_instr[14:12];
    assign f7      = in_instr[31:25];
    assign rs2_raw = in_instr[24:20];
    // Rounding modes 101 and 110 are reserved
    assign rm_ok   = (f3 != 3'b101) && (f3 != 3'b110);

    // Match opcode/funct fields to an operation and its encoding format
    always_comb begin
        op  = OP_ILLEGAL;
        fmt = FMT_NONE;
        case (opcode)
            OPC_LUI:   begin op = OP_LUI;   fmt = FMT_U; end
            OPC_AUIPC: begin op = OP_AUIPC; fmt = FMT_U; end
            OPC_JAL:   begin op = OP_JAL;   fmt = FMT_J; end
            OPC_JALR: begin
                fmt = FMT_I;
                if (f3 == 3'b000) op = OP_JALR;
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                case (f3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_BLTU;
                    3'b111:  op = OP_BGEU;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_LOAD: begin
                fmt = FMT_I;
                case (f3)
                    3'b000:  op = OP_LB;
                    3'b001:  op = OP_LH;
                    3'b010:  op = OP_LW;
                    3'b100:  op = OP_LBU;
                    3'b101:  op = OP_LHU;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_STORE: begin
                fmt = FMT_S;
                case (f3)
                    3'b000:  op = OP_SB;
                    3'b001:  op = OP_SH;
                    3'b010:  op = OP_SW;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_OPIMM: begin
                fmt = FMT_I;
                case (f3)
                    3'b000: op = OP_ADDI;
                    3'b010: op = OP_SLTI;
                    3'b011: op = OP_SLTIU;
                    3'b100: op = OP_XORI;
                    3'b110: op = OP_ORI;
                    3'b111: op = OP_ANDI;
                    3'b001: if (f7 == F7_BASE) op = OP_SLLI;
                    3'b101: begin
                        if (f7 == F7_BASE)     op = OP_SRLI;
                        else if (f7 == F7_ALT) op = OP_SRAI;
                    end
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_OP: begin
                fmt = FMT_R;
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  op = OP_ADD;
                        3'b001:  op = OP_SLL;
                        3'b010:  op = OP_SLT;
                        3'b011:  op = OP_SLTU;
                        3'b100:  op = OP_XOR;
                        3'b101:  op = OP_SRL;
                        3'b110:  op = OP_OR;
                        default: op = OP_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    if (f3 == 3'b000)      op = OP_SUB;
                    else if (f3 == 3'b101) op = OP_SRA;
                end else if (f7 == F7_MULDIV && ENABLE_M) begin
                    case (f3)
                        3'b000:  op = OP_MUL;
                        3'b001:  op = OP_MULH;
                        3'b010:  op = OP_MULHSU;
                        3'b011:  op = OP_MULHU;
                        3'b100:  op = OP_DIV;
                        3'b101:  op = OP_DIVU;
                        3'b110:  op = OP_REM;
                        default: op = OP_REMU;
                    endcase
                end
            end
            OPC_MISCMEM: begin
                fmt = FMT_I;
                if (f3 == 3'b000) op = OP_FENCE;
            end
            OPC_SYSTEM: begin
                // Only the exact ecall/ebreak words; no fields to report
                if (in_instr == INSTR_ECALL)       op = OP_ECALL;
                else if (in_instr == INSTR_EBREAK) op = OP_EBREAK;
            end
            OPC_LOADFP: begin
                fmt = FMT_I;
                if (ENABLE_F && f3 == 3'b010) op = OP_FLW;
            end
            OPC_STOREFP: begin
                fmt = FMT_S;
                if (ENABLE_F && f3 == 3'b010) op = OP_FSW;
            end
            OPC_OPFP: begin
                fmt = FMT_R;
                if (ENABLE_F) begin
                    case (f7)
                        F7_FADD: if (rm_ok) op = OP_FADD;
                        F7_FSUB: if (rm_ok) op = OP_FSUB;
                        F7_FMUL: if (rm_ok) op = OP_FMUL;
                        F7_FDIV: if (rm_ok) op = OP_FDIV;
                        F7_FSQRT: if (rm_ok && rs2_raw == 5'd0) op = OP_FSQRT;
                        F7_FSGNJ: begin
                            if (f3 == 3'b000)      op = OP_FSGNJ;
                            else if (f3 == 3'b001) op = OP_FSGNJN;
                            else if (f3 == 3'b010) op = OP_FSGNJX;
                        end
                        F7_FCMP: begin
                            if (f3 == 3'b010)      op = OP_FEQ;
                            else if (f3 == 3'b000) op = OP_FLE;
                        end
                        F7_FCVT_W_S: if (rm_ok && rs2_raw == 5'd0) op = OP_FCVT_W_S;
                        F7_FCVT_S_W: if (rm_ok && rs2_raw == 5'd0) op = OP_FCVT_S_W;
                        F7_FMV_X_W:  if (f3 == 3'b000 && rs2_raw == 5'd0) op = OP_FMV_X_W;
                        F7_FMV_W_X:  if (f3 == 3'b000 && rs2_raw == 5'd0) op = OP_FMV_W_X;
                        default: op = OP_ILLEGAL;
                    endcase
                end
            end
            default: op = OP_ILLEGAL;
        endcase
        // An unmatched encoding carries no fields at all
        if (op == OP_ILLEGAL) fmt = FMT_NONE;
    end

    // Expose only the register fields the format actually has
    always_comb begin
        dec.op      = op;
        dec.illegal = (op == OP_ILLEGAL);
        dec.imm     = imm_of(fmt, in_instr);
        dec.rd      = '0;
        dec.rs1     = '0;
        dec.rs2     = '0;
        case (fmt)
            FMT_R: begin
                dec.rd  = in_instr[11:7];
                dec.rs1 = in_instr[19:15];
                dec.rs2 = in_instr[24:20];
            end
            FMT_I: begin
                dec.rd  = in_instr[11:7];
                dec.rs1 = in_instr[19:15];
            end
            FMT_S, FMT_B: begin
                dec.rs1 = in_instr[19:15];
                dec.rs2 = in_instr[24:20];
            end
            FMT_U, FMT_J: dec.rd = in_instr[11:7];
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: combinational decode feeding a small in-order output buffer.
module decode_stage
    import decode_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1,
    parameter bit ENABLE_F = 1'b1,
    parameter int DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_pc,
    input  logic [31:0]             in_instr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output instr_op_t               out_op,
    output logic [4:0]              out_rd,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [31:0]             out_imm,
    output logic [31:0]             out_pc,
    output logic                    out_illegal,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("decode_stage: DEPTH must be a power of two >= 2");
    end

    decoded_t      in_dec;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    entry_t        head;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    decode_logic #(
        .ENABLE_M (ENABLE_M),
        .ENABLE_F (ENABLE_F)
    ) u_decode (
        .in_instr (in_instr),
        .dec      (in_dec)
    );

    assign in_ready  = !rst && (count_q < DEPTH_C);
    assign out_valid = !rst && (count_q != '0);
    // A flush swallows both the offered word and any pop in the same cycle
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign head      = mem_q[rptr_q];
    assign count     = count_q;

    // Next pointer/count/storage; pointers wrap naturally since DEPTH is 2^PW
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = '{dec: in_dec, pc: in_pc};
                wptr_d        = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers; reset discards everything like a flush
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: it is only visible through count_q
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Head entry outputs, forced to zero during reset
    always_comb begin
        out_op      = OP_ILLEGAL;
        out_rd      = '0;
        out_rs1     = '0;
        out_rs2     = '0;
        out_imm     = '0;
        out_pc      = '0;
        out_illegal = 1'b0;
        if (!rst) begin
            out_op      = head.dec.op;
            out_rd      = head.dec.rd;
            out_rs1     = head.dec.rs1;
            out_rs2     = head.dec.rs2;
            out_imm     = head.dec.imm;
            out_pc      = head.pc;
            out_illegal = head.dec.illegal;
        end
    end

endmodule
